// File: rtl/bitblt_mul_arbiter_if.sv
// Handshake bundle between the bitblt requesters and the shared multiplier.
// Carries NUM_REQ operand channels (valid/ready, A, B) and one tagged result channel.
interface bitblt_mul_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int A_W     = 17,
    parameter int B_W     = 19,
    parameter int P_W     = 35,
    parameter int ID_W    = 1
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [P_W-1:0]         rsp_data;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_data
    );
endinterface

// File: rtl/bitblt_mul_arbiter.sv
// Shared unsigned A_W x B_W multiplier, round-robin arbitrated among NUM_REQ requesters.
// Ports: ap_clk, ap_rst (sync, active-high), bus (slave side of bitblt_mul_arbiter_if):
//   req_valid/req_ready/req_a/req_b per requester, rsp_valid/rsp_ready/rsp_id/rsp_data.
// Define BITBLT_MUL_ARB_PIPE2_EN to add a product register stage (latency 2 instead of 1).
module bitblt_mul_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int A_W     = 17,
    parameter int B_W     = 19,
    parameter int P_W     = 35,
    parameter int ID_W    = 1
) (
    input logic                 ap_clk,
    input logic                 ap_rst,
    bitblt_mul_arbiter_if.slave bus
);
    logic [ID_W-1:0]    rr_ptr;
    logic               gnt_vld;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [A_W-1:0]     sel_a;
    logic [B_W-1:0]     sel_b;
    logic [P_W-1:0]     prod;
    logic               can_issue;
    logic               accept;

    logic               out_vld;
    logic [ID_W-1:0]    out_id;
    logic [P_W-1:0]     out_data;

    // Scan distance k = 1..NUM_REQ past rr_ptr; the first valid requester wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!gnt_vld && bus.req_valid[i] &&
                    (int'(rr_ptr) + k == i ||
                     int'(rr_ptr) + k == i + NUM_REQ)) begin
                    gnt_vld   = 1'b1;
                    gnt_idx   = ID_W'(i);
                    gnt_oh[i] = 1'b1;
                    sel_a     = bus.req_a[i*A_W +: A_W];
                    sel_b     = bus.req_b[i*B_W +: B_W];
                end
            end
        end
    end

    // Low P_W bits of a product depend only on the low P_W bits of each operand.
    assign prod = P_W'(sel_a) * P_W'(sel_b);

    assign accept        = gnt_vld & can_issue & ~ap_rst;
    assign bus.req_ready = accept ? gnt_oh : '0;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rr_ptr <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            rr_ptr <= gnt_idx;
        end
    end

`ifdef BITBLT_MUL_ARB_PIPE2_EN
    logic            s1_vld;
    logic [ID_W-1:0] s1_id;
    logic [P_W-1:0]  s1_data;
    logic            out_adv;

    assign out_adv   = ~out_vld | bus.rsp_ready;
    assign can_issue = ~s1_vld | out_adv;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_vld  <= 1'b0;
            s1_id   <= '0;
            s1_data <= '0;
        end else if (can_issue) begin
            s1_vld <= accept;
            if (accept) begin
                s1_id   <= gnt_idx;
                s1_data <= prod;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            out_vld  <= 1'b0;
            out_id   <= '0;
            out_data <= '0;
        end else if (out_adv) begin
            out_vld <= s1_vld;
            if (s1_vld) begin
                out_id   <= s1_id;
                out_data <= s1_data;
            end
        end
    end
`else
    assign can_issue = ~out_vld | bus.rsp_ready;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            out_vld  <= 1'b0;
            out_id   <= '0;
            out_data <= '0;
        end else if (can_issue) begin
            out_vld <= accept;
            if (accept) begin
                out_id   <= gnt_idx;
                out_data <= prod;
            end
        end
    end
`endif

    assign bus.rsp_valid = out_vld;
    assign bus.rsp_id    = out_id;
    assign bus.rsp_data  = out_data;
endmodule

// File: tb/tb_bitblt_mul_arbiter.sv
// Self-checking bench for bitblt_mul_arbiter: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_bitblt_mul_arbiter;
    localparam int N    = 2;
    localparam int A_W  = 17;
    localparam int B_W  = 19;
    localparam int P_W  = 35;
    localparam int ID_W = 1;
`ifdef BITBLT_MUL_ARB_PIPE2_EN
    localparam int LAT  = 2;
`else
    localparam int LAT  = 1;
`endif

    logic           ap_clk;
    logic           ap_rst;
    logic [N-1:0]   rv;
    logic [A_W-1:0] ra [N];
    logic [B_W-1:0] rb [N];
    logic           rsp_ready;

    bitblt_mul_arbiter_if #(
        .NUM_REQ(N), .A_W(A_W), .B_W(B_W), .P_W(P_W), .ID_W(ID_W)
    ) bus ();

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign bus.req_a[i*A_W +: A_W] = ra[i];
        assign bus.req_b[i*B_W +: B_W] = rb[i];
    end
    assign bus.req_valid = rv;
    assign bus.rsp_ready = rsp_ready;

    bitblt_mul_arbiter #(
        .NUM_REQ(N), .A_W(A_W), .B_W(B_W), .P_W(P_W), .ID_W(ID_W)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .bus(bus)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [P_W-1:0] mul_ref(input logic [A_W-1:0] a,
                                               input logic [B_W-1:0] b);
        logic [63:0] f;
        f = 64'(a) * 64'(b);
        return f[P_W-1:0];
    endfunction

    // Reference model: results in flight are a FIFO; each entry becomes visible
    // at the output no earlier than LAT cycles after accept and no earlier
    // than the cycle after its predecessor left. Capacity is LAT results.
    typedef struct {
        int             id;
        logic [P_W-1:0] data;
        int             avail;
    } exp_t;

    exp_t q[$];
    int   rr = N - 1;
    int   cyc = 0;
    bit   acc;
    int   idx;
    int   obs_id[$];

    task automatic tick();
        logic [N-1:0] er;
        int g;
        int i;
        bit ok;
        bit vis;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            i = (rr + k) % N;
            if (g < 0 && rv[i]) g = i;
        end
        ok = !ap_rst && (q.size() < LAT || rsp_ready);
        er = '0;
        if (ok && g >= 0) er[g] = 1'b1;
        check("req_ready", 64'(bus.req_ready), 64'(er));
        vis = q.size() > 0 && q[0].avail <= cyc;
        check("rsp_valid", 64'(bus.rsp_valid), 64'(vis));
        if (vis) begin
            check("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
            check("rsp_data", 64'(bus.rsp_data), 64'(q[0].data));
        end
        if (bus.rsp_valid === 1'b1 && rsp_ready) obs_id.push_back(int'(bus.rsp_id));
        acc = ok && g >= 0;
        idx = g;
        if (ap_rst) begin
            q.delete();
            rr = N - 1;
        end else begin
            if (vis && rsp_ready) begin
                void'(q.pop_front());
                if (q.size() > 0 && q[0].avail < cyc + 1) q[0].avail = cyc + 1;
            end
            if (acc) begin
                q.push_back('{id: g, data: mul_ref(ra[g], rb[g]), avail: cyc + LAT});
                rr = g;
            end
        end
        cyc++;
    endtask

    task automatic next();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk();
        @(negedge ap_clk);
        tick();
    endtask

    function automatic logic [A_W-1:0] rnd_a();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return A_W'($urandom);
        endcase
    endfunction

    function automatic logic [B_W-1:0] rnd_b();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return B_W'($urandom);
        endcase
    endfunction

    typedef struct {
        int             r;
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic [P_W-1:0] p;
    } vec_t;

    vec_t tbl [8];
    int   issued;
    bit   bp_more;
    logic [N-1:0] oh;

    initial begin
        tbl[0] = '{0, 17'd3,       19'd5,       35'd15};
        tbl[1] = '{1, 17'd0,       19'h7FFFF,   35'd0};
        tbl[2] = '{0, 17'h1FFFF,   19'h7FFFF,   35'h7_FFF6_0001};
        tbl[3] = '{1, 17'd1,       19'd1,       35'd1};
        tbl[4] = '{0, 17'h10000,   19'h40000,   35'h4_0000_0000};
        tbl[5] = '{1, 17'h1FFFF,   19'h40000,   35'h7_FFFC_0000};
        tbl[6] = '{0, 17'd12345,   19'd6789,    35'd83810205};
        tbl[7] = '{1, 17'h1FFFF,   19'd0,       35'd0};

        ap_rst    = 1'b1;
        rv        = '1;
        rsp_ready = 1'b1;
        ra[0] = 17'd3;  rb[0] = 19'd5;
        ra[1] = 17'd21; rb[1] = 19'd33;

        // Reset held with both requesters valid.
        repeat (3) begin
            next();
            chk();
            check("rst_id", 64'(bus.rsp_id), 64'd0);
            check("rst_data", 64'(bus.rsp_data), 64'd0);
        end
        next();
        ap_rst = 1'b0;
        chk();
        check("first_grant", 64'(bus.req_ready), 64'(2'b01));

        // Round robin: six accepts from two always-valid requesters.
        obs_id.delete();
        issued = acc ? 1 : 0;
        for (int c = 0; c < 12; c++) begin
            next();
            if (acc) begin
                if (issued < 5) begin
                    ra[idx] = A_W'(100 + issued * 7 + idx);
                    rb[idx] = B_W'(1000 + issued * 3);
                end else begin
                    rv[idx] = 1'b0;
                end
            end
            chk();
            if (acc) issued++;
        end
        check("rr_count", 64'(obs_id.size()), 64'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < obs_id.size()) check("rr_seq", 64'(obs_id[k]), 64'(k % 2));
        end

        // Vector table: one isolated operation each, latency checked explicitly.
        for (int v = 0; v < 8; v++) begin
            next();
            rv = '0;
            rv[tbl[v].r] = 1'b1;
            ra[tbl[v].r] = tbl[v].a;
            rb[tbl[v].r] = tbl[v].b;
            chk();
            oh = '0;
            oh[tbl[v].r] = 1'b1;
            check("tbl_grant", 64'(bus.req_ready), 64'(oh));
            next();
            rv = '0;
            for (int l = 1; l < LAT; l++) begin
                chk();
                check("tbl_lat", 64'(bus.rsp_valid), 64'd0);
                next();
            end
            chk();
            check("tbl_vld", 64'(bus.rsp_valid), 64'd1);
            check("tbl_id", 64'(bus.rsp_id), 64'(tbl[v].r));
            check("tbl_data", 64'(bus.rsp_data), 64'(tbl[v].p));
        end
        next();
        chk();

        // Backpressure: result held four cycles, then released.
        obs_id.delete();
        bp_more = 1'b1;
        next();
        rv = '0;
        rv[0] = 1'b1; ra[0] = 17'd7; rb[0] = 19'd9;
        chk();
        next();
        rv[0] = 1'b0;
        for (int l = 1; l < LAT; l++) begin
            chk();
            next();
        end
        rsp_ready = 1'b0;
        rv[1] = 1'b1; ra[1] = 17'd11; rb[1] = 19'd13;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                next();
                if (acc) begin
                    rv[idx] = 1'b0;
                    if (idx == 1 && bp_more) begin
                        rv[0] = 1'b1; ra[0] = 17'd2; rb[0] = 19'd21;
                        bp_more = 1'b0;
                    end
                end
            end
            chk();
            check("bp_vld", 64'(bus.rsp_valid), 64'd1);
            check("bp_data", 64'(bus.rsp_data), 64'd63);
            check("bp_id", 64'(bus.rsp_id), 64'd0);
            check("bp_ready", 64'(bus.req_ready),
                  64'((LAT == 2 && k == 0) ? 2'b10 : 2'b00));
        end
        next();
        rsp_ready = 1'b1;
        chk();
        check("bp_release", 64'(bus.req_ready), 64'(LAT == 1 ? 2'b10 : 2'b01));
        repeat (6) begin
            next();
            if (acc) begin
                rv[idx] = 1'b0;
                if (idx == 1 && bp_more) begin
                    rv[0] = 1'b1; ra[0] = 17'd2; rb[0] = 19'd21;
                    bp_more = 1'b0;
                end
            end
            chk();
        end
        check("bp_count", 64'(obs_id.size()), 64'd3);

        // Reset while a result is pending: it must be dropped.
        next();
        rsp_ready = 1'b0;
        rv = '0;
        rv[0] = 1'b1; ra[0] = 17'd100; rb[0] = 19'd200;
        chk();
        next();
        rv[0] = 1'b0;
        for (int l = 1; l < LAT; l++) begin
            chk();
            next();
        end
        chk();
        check("mr_pending", 64'(bus.rsp_valid), 64'd1);
        next();
        ap_rst = 1'b1;
        rv = '1;
        ra[0] = 17'd4; rb[0] = 19'd6;
        ra[1] = 17'd9; rb[1] = 19'd9;
        chk();
        obs_id.delete();
        next();
        ap_rst = 1'b0;
        rsp_ready = 1'b1;
        chk();
        check("mr_drop", 64'(bus.rsp_valid), 64'd0);
        check("mr_first_grant", 64'(bus.req_ready), 64'(2'b01));
        repeat (6) begin
            next();
            if (acc) rv[idx] = 1'b0;
            chk();
        end
        check("mr_count", 64'(obs_id.size()), 64'd2);

        // Randomized traffic, occasional reset, random backpressure.
        for (int c = 0; c < 600; c++) begin
            next();
            ap_rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < N; i++) begin
                if ((acc && idx == i) || !rv[i]) begin
                    rv[i] = ($urandom_range(0, 2) != 0);
                    ra[i] = rnd_a();
                    rb[i] = rnd_b();
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            chk();
        end
        next();
        ap_rst = 1'b0;
        rv = '0;
        rsp_ready = 1'b1;
        repeat (4) begin
            chk();
            next();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
